// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the shared MIPS datapath.
// The master side is the sequencer; the slave side is the datapath.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dest;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero_flag, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dest, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_src, alu_control, instr_done,
           illegal_op
  );

  modport slave (
    output opcode, funct, zero_flag, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dest, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_src, alu_control, instr_done,
           illegal_op
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: steps one instruction through the shared
// memory/ALU/register-file datapath, holding state while memory is not ready.
module mc_control_fsm (
  input  logic             clk,
  input  logic             rst,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Unknown funct codes fall back to add so the datapath sees a defined operation.
  function automatic logic [2:0] alu_decode(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      6'b100000: op = ALU_ADD;
      6'b100010: op = ALU_SUB;
      6'b100100: op = ALU_AND;
      6'b100101: op = ALU_OR;
      6'b101010: op = ALU_SLT;
      default:   op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_t     state_r;
  state_t     state_next_s;

  logic       pc_write_s;
  logic       branch_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dest_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] pc_src_s;
  logic [2:0] alu_control_s;
  logic       instr_done_s;
  logic       illegal_op_s;

  // State register with synchronous reset back to instruction fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_next_s  = state_r;
    pc_write_s    = 1'b0;
    branch_s      = 1'b0;
    iord_s        = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    reg_dest_s    = 1'b0;
    mem_to_reg_s  = 1'b0;
    reg_write_s   = 1'b0;
    alu_src_a_s   = 1'b0;
    alu_src_b_s   = 2'b00;
    pc_src_s      = 2'b00;
    alu_control_s = ALU_ADD;
    instr_done_s  = 1'b0;
    illegal_op_s  = 1'b0;

    case (state_r)
      FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        if (bus.mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = DECODE;
        end else begin
          state_next_s = FETCH;
        end
      end

      // Branch target is precomputed here so BRANCH only has to compare.
      DECODE: begin
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_RTYPE:     state_next_s = EXEC;
          OP_BEQ:       state_next_s = BRANCH;
          OP_ADDI:      state_next_s = ADDIEX;
          OP_J:         state_next_s = JUMP;
          default: begin
            illegal_op_s = 1'b1;
            state_next_s = FETCH;
          end
        endcase
      end

      MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_SW) begin
          state_next_s = MEMWR;
        end else begin
          state_next_s = MEMRD;
        end
      end

      MEMRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        if (bus.mem_ready) begin
          state_next_s = MEMWB;
        end else begin
          state_next_s = MEMRD;
        end
      end

      MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = FETCH;
      end

      MEMWR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        if (bus.mem_ready) begin
          instr_done_s = 1'b1;
          state_next_s = FETCH;
        end else begin
          state_next_s = MEMWR;
        end
      end

      EXEC: begin
        alu_src_a_s   = 1'b1;
        alu_control_s = alu_decode(bus.funct);
        state_next_s  = ALUWB;
      end

      ALUWB: begin
        reg_write_s  = 1'b1;
        reg_dest_s   = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = FETCH;
      end

      BRANCH: begin
        alu_src_a_s   = 1'b1;
        alu_control_s = ALU_SUB;
        pc_src_s      = 2'b01;
        branch_s      = 1'b1;
        instr_done_s  = 1'b1;
        state_next_s  = FETCH;
      end

      ADDIEX: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        state_next_s = ADDIWB;
      end

      ADDIWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = FETCH;
      end

      JUMP: begin
        pc_src_s     = 2'b10;
        pc_write_s   = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = FETCH;
      end

      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // A taken branch loads the PC from ALUOut only when the subtraction was zero.
  assign bus.pc_en       = pc_write_s | (branch_s & bus.zero_flag);
  assign bus.iord        = iord_s;
  assign bus.mem_read    = mem_read_s;
  assign bus.mem_write   = mem_write_s;
  assign bus.ir_write    = ir_write_s;
  assign bus.reg_dest    = reg_dest_s;
  assign bus.mem_to_reg  = mem_to_reg_s;
  assign bus.reg_write   = reg_write_s;
  assign bus.alu_src_a   = alu_src_a_s;
  assign bus.alu_src_b   = alu_src_b_s;
  assign bus.pc_src      = pc_src_s;
  assign bus.alu_control = alu_control_s;
  assign bus.instr_done  = instr_done_s;
  assign bus.illegal_op  = illegal_op_s;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded into the per-cycle
// control vectors the datapath should see, then compared cycle by cycle.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  // rdy/zr: 0 or 1 = drive that value, 2 = drive a random value (don't care)
  typedef struct {
    int   rdy;
    int   zr;
    ctl_t exp;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         z;
    int         nf;
    int         nm;
    int         lat;
    string      name;
  } tv_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  cyc_t sched[$];

  mc_control_fsm_if ifc ();

  mc_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.alu_control = 3'b010;
    return c;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] fn);
    if (fn == 6'h20) return 3'b010;
    else if (fn == 6'h22) return 3'b110;
    else if (fn == 6'h24) return 3'b000;
    else if (fn == 6'h25) return 3'b001;
    else if (fn == 6'h2a) return 3'b111;
    else return 3'b010;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'd35 || op == 6'd43 || op == 6'd0 || op == 6'd4 ||
           op == 6'd8 || op == 6'd2;
  endfunction

  function automatic int lat_ref(input logic [5:0] op, input int nf, input int nm);
    int l;
    if (op == 6'd35) l = 5 + nm;
    else if (op == 6'd43) l = 4 + nm;
    else if (op == 6'd0 || op == 6'd8) l = 4;
    else if (op == 6'd4 || op == 6'd2) l = 3;
    else l = 2;
    return l + nf;
  endfunction

  function automatic ctl_t get_ctl();
    ctl_t c;
    c.pc_en       = ifc.pc_en;
    c.iord        = ifc.iord;
    c.mem_read    = ifc.mem_read;
    c.mem_write   = ifc.mem_write;
    c.ir_write    = ifc.ir_write;
    c.reg_dest    = ifc.reg_dest;
    c.mem_to_reg  = ifc.mem_to_reg;
    c.reg_write   = ifc.reg_write;
    c.alu_src_a   = ifc.alu_src_a;
    c.alu_src_b   = ifc.alu_src_b;
    c.pc_src      = ifc.pc_src;
    c.alu_control = ifc.alu_control;
    c.instr_done  = ifc.instr_done;
    c.illegal_op  = ifc.illegal_op;
    return c;
  endfunction

  task automatic check_ctl(input string name, input int cyc, input ctl_t exp);
    ctl_t act;
    act = get_ctl();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int rdy, input int zr, input ctl_t c);
    cyc_t e;
    e.rdy = rdy;
    e.zr  = zr;
    e.exp = c;
    sched.push_back(e);
  endtask

  // Expand one instruction into the control vectors of each of its cycles.
  task automatic expand(input logic [5:0] op, input logic [5:0] fn, input bit z,
                        input int nf, input int nm);
    ctl_t c;
    sched.delete();
    c = idle();
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    for (int i = 0; i < nf; i++) push(0, 2, c);
    c.ir_write = 1'b1;
    c.pc_en    = 1'b1;
    push(1, 2, c);

    c = idle();
    c.alu_src_b  = 2'b11;
    c.illegal_op = !is_legal(op);
    push(2, 2, c);

    if (op == 6'd35 || op == 6'd43) begin
      c = idle();
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      push(2, 2, c);
      c = idle();
      c.iord      = 1'b1;
      c.mem_read  = (op == 6'd35);
      c.mem_write = (op == 6'd43);
      for (int i = 0; i < nm; i++) push(0, 2, c);
      c.instr_done = (op == 6'd43);
      push(1, 2, c);
      if (op == 6'd35) begin
        c = idle();
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
        push(2, 2, c);
      end
    end else if (op == 6'd0) begin
      c = idle();
      c.alu_src_a   = 1'b1;
      c.alu_control = alu_ref(fn);
      push(2, 2, c);
      c = idle();
      c.reg_write  = 1'b1;
      c.reg_dest   = 1'b1;
      c.instr_done = 1'b1;
      push(2, 2, c);
    end else if (op == 6'd4) begin
      c = idle();
      c.alu_src_a   = 1'b1;
      c.alu_control = 3'b110;
      c.pc_src      = 2'b01;
      c.instr_done  = 1'b1;
      c.pc_en       = z;
      push(2, int'(z), c);
    end else if (op == 6'd8) begin
      c = idle();
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      push(2, 2, c);
      c = idle();
      c.reg_write  = 1'b1;
      c.instr_done = 1'b1;
      push(2, 2, c);
    end else if (op == 6'd2) begin
      c = idle();
      c.pc_src     = 2'b10;
      c.pc_en      = 1'b1;
      c.instr_done = 1'b1;
      push(2, 2, c);
    end
  endtask

  // Entered and left one time unit after a rising edge, with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int nf, input int nm, input int lat,
                           input string name);
    int meas;
    meas = 0;
    ifc.opcode = op;
    ifc.funct  = fn;
    expand(op, fn, z, nf, nm);
    for (int i = 0; i < sched.size(); i++) begin
      ifc.mem_ready = (sched[i].rdy == 2) ? 1'($urandom % 2) : (sched[i].rdy != 0);
      ifc.zero_flag = (sched[i].zr == 2) ? 1'($urandom % 2) : (sched[i].zr != 0);
      @(negedge clk);
      check_ctl(name, i, sched[i].exp);
      if (meas == 0 && (ifc.instr_done === 1'b1 || ifc.illegal_op === 1'b1))
        meas = i + 1;
      @(posedge clk);
      #1;
    end
    total++;
    if (meas != lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, meas, lat);
    end
  endtask

  tv_t  tv[$];
  ctl_t fx;

  initial begin
    total = 0;
    bad   = 0;
    tv = '{
      '{6'b100011, 6'h00, 1'b0, 0, 0, 5, "lw"},
      '{6'b101011, 6'h00, 1'b0, 0, 0, 4, "sw"},
      '{6'b101011, 6'h00, 1'b0, 0, 3, 7, "sw_stall3"},
      '{6'b000000, 6'h20, 1'b0, 0, 0, 4, "r_add"},
      '{6'b000000, 6'h22, 1'b0, 0, 0, 4, "r_sub"},
      '{6'b000000, 6'h24, 1'b0, 0, 0, 4, "r_and"},
      '{6'b000000, 6'h25, 1'b0, 0, 0, 4, "r_or"},
      '{6'b000000, 6'h2a, 1'b0, 0, 0, 4, "r_slt"},
      '{6'b000000, 6'h3f, 1'b0, 0, 0, 4, "r_unknown"},
      '{6'b000100, 6'h00, 1'b1, 0, 0, 3, "beq_taken"},
      '{6'b000100, 6'h00, 1'b0, 0, 0, 3, "beq_not_taken"},
      '{6'b001000, 6'h00, 1'b0, 0, 0, 4, "addi"},
      '{6'b000010, 6'h00, 1'b0, 0, 0, 3, "j"},
      '{6'b111111, 6'h00, 1'b0, 0, 0, 2, "illegal"},
      '{6'b100011, 6'h00, 1'b0, 2, 1, 8, "lw_stalls"}
    };

    rst = 1'b1;
    ifc.opcode = 6'b100011;
    ifc.funct = 6'h00;
    ifc.zero_flag = 1'b0;
    ifc.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset: FETCH outputs, with pc_en/ir_write following mem_ready.
    fx = idle();
    fx.mem_read  = 1'b1;
    fx.alu_src_b = 2'b01;
    @(negedge clk);
    check_ctl("reset_hold_rdy0", 0, fx);
    @(posedge clk);
    #1;
    ifc.mem_ready = 1'b1;
    fx.pc_en    = 1'b1;
    fx.ir_write = 1'b1;
    @(negedge clk);
    check_ctl("reset_hold_rdy1", 1, fx);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tv[k])
      run_instr(tv[k].op, tv[k].fn, tv[k].z, tv[k].nf, tv[k].nm, tv[k].lat, tv[k].name);

    // Reset while a load is stalled in its memory-read cycle.
    ifc.opcode = 6'b100011;
    ifc.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ifc.mem_ready = 1'b0;
    fx = idle();
    fx.mem_read = 1'b1;
    fx.iord     = 1'b1;
    @(negedge clk);
    check_ctl("pre_reset_memrd", 0, fx);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fx = idle();
    fx.mem_read  = 1'b1;
    fx.alu_src_b = 2'b01;
    @(negedge clk);
    check_ctl("reset_mid_memrd", 1, fx);
    @(posedge clk);
    #1;
    // The abandoned load must not have left the sequencer anywhere but FETCH.
    run_instr(6'b000010, 6'h00, 1'b0, 1, 0, 4, "j_after_reset");

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      logic [5:0] legal_ops[6];
      logic [5:0] functs[5];
      int nf;
      int nm;
      legal_ops = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd8, 6'd2};
      functs    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom);
        for (int t = 0; t < 8 && is_legal(op); t++) op = 6'($urandom);
        if (is_legal(op)) op = 6'b111111;
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
      nf = $urandom_range(0, 3);
      nm = $urandom_range(0, 3);
      run_instr(op, fn, 1'($urandom % 2), nf, nm, lat_ref(op, nf, nm), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
